// File: rtl/mac_result_drain_pkg.sv
// Shared constants and types for the MAC array result drain.
// Imported by the drain top and its requantiser.
package mac_result_drain_pkg;

   localparam int unsigned DIM    = 4;
   localparam int unsigned ACC_W  = 32;
   localparam int unsigned IN_W   = 8;
   localparam int unsigned N_ELEM = DIM * DIM;
   localparam int unsigned IDX_W  = $clog2(N_ELEM);

   typedef enum logic {
      IDLE,
      STREAM
   } state_e;

endpackage

// File: rtl/mac_result_drain_requant.sv
// Combinational logical right shift and unsigned saturation of one word.
// Kept standalone so a writeback stage can reuse it.
module mac_requant
   import mac_result_drain_pkg::*;
#(
   parameter int unsigned OUT_W = 32,
   parameter int unsigned SHIFT = 0
) (
   input  logic [ACC_W-1:0] acc_i,
   output logic [OUT_W-1:0] data_o,
   output logic             sat_o
);

   logic [ACC_W-1:0] s;

   assign s = acc_i >> SHIFT;

   if (OUT_W < ACC_W) begin : g_sat
      logic ovf;
      assign ovf    = |s[ACC_W-1:OUT_W];
      assign data_o = ovf ? '1 : s[OUT_W-1:0];
      assign sat_o  = ovf;
   end else begin : g_full
      assign data_o = s[OUT_W-1:0];
      assign sat_o  = 1'b0;
   end

endmodule

// File: rtl/mac_result_drain.sv
// Snapshots the 4x4 accumulator results on done and streams them
// out row-major, one requantised word per valid/ready handshake.
module mac_result_drain
   import mac_result_drain_pkg::*;
#(
   parameter int unsigned OUT_W = 32,
   parameter int unsigned SHIFT = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             done,
   input  logic [ACC_W-1:0] c [0:DIM-1][0:DIM-1],
   output logic [OUT_W-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:0]       out_row,
   output logic [1:0]       out_col,
   output logic             out_last,
   output logic             out_sat,
   output logic             busy,
   output logic             overrun
);

   localparam logic [IDX_W-1:0] LAST = IDX_W'(N_ELEM - 1);

   state_e           state_q;
   logic [IDX_W-1:0] idx_q;
   logic [IDX_W-1:0] idx_d;
   logic             done_q;
   logic             overrun_q;
   logic [ACC_W-1:0] mem_q [N_ELEM];
   logic [ACC_W-1:0] c_flat [N_ELEM];
   logic [ACC_W-1:0] src;
   logic [OUT_W-1:0] rq_data;
   logic             rq_sat;
   logic             done_rise;

   logic [OUT_W-1:0] out_data_q;
   logic             out_valid_q;
   logic [1:0]       out_row_q;
   logic [1:0]       out_col_q;
   logic             out_last_q;
   logic             out_sat_q;

   for (genvar r = 0; r < DIM; r++) begin : g_r
      for (genvar k = 0; k < DIM; k++) begin : g_k
         assign c_flat[r*DIM+k] = c[r][k];
      end
   end

   assign done_rise = done & ~done_q;

   always_comb begin
      idx_d = idx_q;
      if (state_q == IDLE) begin
         idx_d = '0;
      end else if (out_ready && idx_q != LAST) begin
         idx_d = idx_q + 1'b1;
      end
   end

   // On capture the buffer is still being written, so read c directly.
   assign src = (state_q == IDLE) ? c_flat[idx_d] : mem_q[idx_d];

   mac_requant #(
      .OUT_W (OUT_W),
      .SHIFT (SHIFT)
   ) u_requant (
      .acc_i  (src),
      .data_o (rq_data),
      .sat_o  (rq_sat)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         done_q      <= 1'b0;
         overrun_q   <= 1'b0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_row_q   <= '0;
         out_col_q   <= '0;
         out_last_q  <= 1'b0;
         out_sat_q   <= 1'b0;
      end else begin
         done_q <= done;
         unique case (state_q)
            IDLE: begin
               if (done_rise) begin
                  mem_q       <= c_flat;
                  idx_q       <= '0;
                  state_q     <= STREAM;
                  out_valid_q <= 1'b1;
                  out_data_q  <= rq_data;
                  out_sat_q   <= rq_sat;
                  out_row_q   <= '0;
                  out_col_q   <= '0;
                  out_last_q  <= 1'b0;
               end
            end
            STREAM: begin
               if (done_rise) begin
                  overrun_q <= 1'b1;
               end
               if (out_ready) begin
                  if (idx_q == LAST) begin
                     state_q     <= IDLE;
                     out_valid_q <= 1'b0;
                     out_last_q  <= 1'b0;
                  end else begin
                     idx_q      <= idx_d;
                     out_data_q <= rq_data;
                     out_sat_q  <= rq_sat;
                     out_row_q  <= idx_d[IDX_W-1:2];
                     out_col_q  <= idx_d[1:0];
                     out_last_q <= (idx_d == LAST);
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign out_row   = out_row_q;
   assign out_col   = out_col_q;
   assign out_last  = out_last_q;
   assign out_sat   = out_sat_q;
   assign busy      = (state_q == STREAM);
   assign overrun   = overrun_q;

endmodule
